reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter onto a shared io-register bus with registered outputs.
// Optional address range checking is enabled by defining REG_ARB_ADDR_CHECK_EN.
module reg_bus_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req0_in,
  input  logic                  req1_in,
  input  logic                  wr0_in,
  input  logic                  wr1_in,
  input  logic [ADDR_WIDTH-1:0] addr0_in,
  input  logic [ADDR_WIDTH-1:0] addr1_in,
  input  logic [DATA_WIDTH-1:0] wdata0_in,
  input  logic [DATA_WIDTH-1:0] wdata1_in,
  output logic                  ack0_out,
  output logic                  ack1_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  err0_out,
  output logic                  err1_out,
  output logic [NUM_REGS-1:0]   reg_en_out,
  output logic                  reg_write_out,
  output logic [DATA_WIDTH-1:0] reg_wdata_out,
  input  logic [DATA_WIDTH-1:0] reg_rdata_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDHOLD, ACK} state_t;

  state_t                state_q, state_d;
  logic                  lat_wr_q, lat_wr_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic                  lat_id_q, lat_id_d;
  logic                  prio_q, prio_d;

  logic                  ack0_d, ack1_d, err0_d, err1_d, write_d;
  logic [DATA_WIDTH-1:0] rdata_d, owdata_d;
  logic [NUM_REGS-1:0]   en_d;

  logic                  gnt1, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  do_ack, ack_id, ack_err;

  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (32'(a) == i) oh[i] = 1'b1;
    return oh;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  always_comb begin
    state_d     = state_q;
    lat_wr_d    = lat_wr_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_id_d    = lat_id_q;
    prio_d      = prio_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata_d     = '0;
    en_d        = '0;
    write_d     = 1'b0;
    owdata_d    = '0;
    do_ack      = 1'b0;
    ack_id      = lat_id_q;
    ack_err     = 1'b0;

    // prio_q set means requester 1 is favoured on a tie
    gnt1      = req1_in & (~req0_in | prio_q);
    sel_wr    = gnt1 ? wr1_in    : wr0_in;
    sel_addr  = gnt1 ? addr1_in  : addr0_in;
    sel_wdata = gnt1 ? wdata1_in : wdata0_in;

    unique case (state_q)
      IDLE: begin
        if (req0_in || req1_in) begin
          lat_wr_d    = sel_wr;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          lat_id_d    = gnt1;
`ifdef REG_ARB_ADDR_CHECK_EN
          if (!in_range(sel_addr)) begin
            state_d = ACK;
            do_ack  = 1'b1;
            ack_id  = gnt1;
            ack_err = 1'b1;
          end else
`endif
          begin
            state_d  = ACCESS;
            en_d     = decode(sel_addr);
            write_d  = sel_wr;
            owdata_d = sel_wdata;
          end
        end
      end
      ACCESS: begin
        if (lat_wr_q) begin
          state_d = ACK;
          do_ack  = 1'b1;
        end else begin
          state_d  = RDHOLD;
          en_d     = decode(lat_addr_q);
          owdata_d = lat_wdata_q;
        end
      end
      RDHOLD: begin
        state_d = ACK;
        do_ack  = 1'b1;
        // out-of-range reads see a floating bus, so substitute zero
        rdata_d = in_range(lat_addr_q) ? reg_rdata_in : '0;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_ack) begin
      ack0_d = ~ack_id;
      ack1_d = ack_id;
      err0_d = ack_err & ~ack_id;
      err1_d = ack_err & ack_id;
      prio_d = ~ack_id;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      lat_wr_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      lat_id_q      <= 1'b0;
      prio_q        <= 1'b0;
      ack0_out      <= 1'b0;
      ack1_out      <= 1'b0;
      err0_out      <= 1'b0;
      err1_out      <= 1'b0;
      rdata_out     <= '0;
      reg_en_out    <= '0;
      reg_write_out <= 1'b0;
      reg_wdata_out <= '0;
    end else begin
      state_q       <= state_d;
      lat_wr_q      <= lat_wr_d;
      lat_addr_q    <= lat_addr_d;
      lat_wdata_q   <= lat_wdata_d;
      lat_id_q      <= lat_id_d;
      prio_q        <= prio_d;
      ack0_out      <= ack0_d;
      ack1_out      <= ack1_d;
      err0_out      <= err0_d;
      err1_out      <= err1_d;
      rdata_out     <= rdata_d;
      reg_en_out    <= en_d;
      reg_write_out <= write_d;
      reg_wdata_out <= owdata_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: vector table plus reset and dropped-request sequences.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [2:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err0, err1, reg_write;
  logic [31:0] rdata, reg_wdata, reg_rdata;
  logic [5:0]  reg_en;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] regs [6];

  always #5 clk = ~clk;

  reg_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .NUM_REGS(6)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_in(req0), .req1_in(req1), .wr0_in(wr0), .wr1_in(wr1),
    .addr0_in(addr0), .addr1_in(addr1), .wdata0_in(wdata0), .wdata1_in(wdata1),
    .ack0_out(ack0), .ack1_out(ack1), .rdata_out(rdata),
    .err0_out(err0), .err1_out(err1),
    .reg_en_out(reg_en), .reg_write_out(reg_write), .reg_wdata_out(reg_wdata),
    .reg_rdata_in(reg_rdata)
  );

  // Register bank environment; undriven bus reads return a recognisable junk word
  always @(posedge clk)
    for (int i = 0; i < 6; i++)
      if (reg_write && reg_en[i]) regs[i] <= reg_wdata;

  always_comb begin
    reg_rdata = 32'hBAD0_BAD0;
    for (int j = 0; j < 6; j++)
      if (reg_en[j]) reg_rdata = regs[j];
  end

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [2:0]  a0, a1;
    logic [31:0] d0, d1;
    int unsigned id;
    logic [5:0]  en;
    int unsigned lat;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic exp_wr;
    exp_wr = (v.id == 1) ? v.w1 : v.w0;
    req0 = v.r0; req1 = v.r1; wr0 = v.w0; wr1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(posedge clk);
    for (int unsigned c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_en", n, c), 32'(reg_en), (c < v.lat) ? 32'(v.en) : 32'd0);
      chk($sformatf("v%0d_c%0d_wstrobe", n, c), 32'(reg_write),
          (c < v.lat) ? 32'(exp_wr) : 32'd0);
      if (c < v.lat && exp_wr)
        chk($sformatf("v%0d_c%0d_wdata", n, c), reg_wdata, (v.id == 1) ? v.d1 : v.d0);
      chk($sformatf("v%0d_c%0d_ack", n, c), 32'({ack1, ack0}),
          (c == v.lat) ? ((v.id == 1) ? 32'd2 : 32'd1) : 32'd0);
      if (c == v.lat) begin
        chk($sformatf("v%0d_rdata", n), rdata, v.rd);
        chk($sformatf("v%0d_err", n), 32'({err1, err0}),
            v.err ? ((v.id == 1) ? 32'd2 : 32'd1) : 32'd0);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //          r0   r1   w0   w1   a0    a1    d0            d1            id en     lat rd            err
    vecs[0] = '{1'b1,1'b0,1'b1,1'b0,3'd2, 3'd0, 32'hDEADBEEF, 32'h0,        0, 6'h04, 2, 32'h0,        1'b0};
    vecs[1] = '{1'b0,1'b1,1'b0,1'b0,3'd0, 3'd2, 32'h0,        32'h0,        1, 6'h04, 3, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1,1'b1,1'b1,1'b1,3'd0, 3'd5, 32'h11111111, 32'h55555555, 0, 6'h01, 2, 32'h0,        1'b0};
    vecs[3] = '{1'b1,1'b1,1'b1,1'b1,3'd0, 3'd5, 32'h11111111, 32'h55555555, 1, 6'h20, 2, 32'h0,        1'b0};
    vecs[4] = '{1'b1,1'b1,1'b1,1'b1,3'd0, 3'd5, 32'h11111111, 32'h55555555, 0, 6'h01, 2, 32'h0,        1'b0};
    vecs[5] = '{1'b1,1'b1,1'b1,1'b1,3'd0, 3'd5, 32'h11111111, 32'h55555555, 1, 6'h20, 2, 32'h0,        1'b0};
    vecs[6] = '{1'b1,1'b0,1'b0,1'b0,3'd0, 3'd0, 32'h0,        32'h0,        0, 6'h01, 3, 32'h11111111, 1'b0};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b0,3'd0, 3'd5, 32'h0,        32'h0,        1, 6'h20, 3, 32'h55555555, 1'b0};
`ifdef REG_ARB_ADDR_CHECK_EN
    vecs[8] = '{1'b1,1'b0,1'b0,1'b0,3'd7, 3'd0, 32'h0,        32'h0,        0, 6'h00, 1, 32'h0,        1'b1};
`else
    vecs[8] = '{1'b1,1'b0,1'b0,1'b0,3'd7, 3'd0, 32'h0,        32'h0,        0, 6'h00, 3, 32'h0,        1'b0};
`endif

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(reg_en), 32'd0);
    chk("rst_acks", 32'({ack1, ack0, err1, err0, reg_write}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    rst_n = 1'b1;

    run_vec(vecs[0], 0);
    run_vec(vecs[1], 1);

    // reset pulsed while a read sits in RDHOLD
    req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    chk("rh_access_en", 32'(reg_en), 32'h04);
    req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rh_rdhold_en", 32'(reg_en), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("rh_async_en", 32'(reg_en), 32'd0);
    chk("rh_async_ack", 32'({ack1, ack0}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rh_noack%0d", k), 32'({ack1, ack0, 2'(reg_en != 0)}), 32'd0);
    end
    rst_n = 1'b1;

    // requester drops req and scrambles its inputs right after being granted
    req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd3; wdata1 = 32'h33333333;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0; wr1 = 1'b0; addr1 = 3'd4; wdata1 = 32'hFFFFFFFF;
    chk("drop_en", 32'(reg_en), 32'h08);
    chk("drop_wstrobe", 32'(reg_write), 32'd1);
    chk("drop_wdata", reg_wdata, 32'h33333333);
    @(negedge clk);
    chk("drop_ack", 32'({ack1, ack0}), 32'd2);
    chk("drop_en_off", 32'(reg_en), 32'd0);
    @(negedge clk);
    chk("drop_idle_ack", 32'({ack1, ack0}), 32'd0);

    for (int n = 2; n < 9; n++) run_vec(vecs[n], n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", 32'({ack1, ack0, 2'(reg_en != 0)}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
